pc_fetch_stage: RTL and testbench
=================================

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have `pc_next_in`, input, 16 bits: PC selected by the upstream PC mux.
REQ-004 SHALL have `redirect`, input, 1 bit: jump/branch taken (mux selector non-zero); flush request.
REQ-005 SHALL have `stall`, input, 1 bit: decode cannot accept; IF/ID must hold.
REQ-006 SHALL have `next_pc_normal`, output, 16 bits: pc+1, fed to the mux normal input.
REQ-007 SHALL have `imem_req`, output, 1 bit, and `imem_addr`, output, 16 bits: instruction fetch request and address.
REQ-008 SHALL have `imem_ack`, input, 1 bit, and `imem_rdata`, input, 16 bits: fetch completion and instruction word (valid with ack).
REQ-009 SHALL have IF/ID register outputs:
- `ifid_instr`, 16 bits
- `ifid_pc`, 16 bits
- `ifid_pc_plus1`, 16 bits
- `ifid_valid`, 1 bit

Function
REQ-010 SHALL compute next_pc_normal = pc+1 combinationally, mod 2^16 (16'hFFFF -> 16'h0000).
REQ-011 SHALL implement four states: BOOT, FETCH, DRAIN, HOLD.
REQ-012 SHALL drive imem_req=1 and imem_addr=pc in FETCH and DRAIN, and imem_req=0 in BOOT and HOLD.
- imem_addr SHALL stay stable while imem_req=1 and ack is absent.
REQ-013 In BOOT, SHALL go to FETCH next cycle regardless of stall.
REQ-014 In FETCH, on ack, !redirect, !stall:
- ifid <= {rdata, pc, pc+1}
- ifid_valid <= 1
- pc <= pc_next_in
- stay in FETCH (one instruction per cycle with zero-wait memory)
REQ-015 In FETCH, on ack, !redirect, stall:
- rdata, pc and pc+1 captured into a one-entry hold buffer
- pc <= pc_next_in
- IF/ID unchanged
- go to HOLD
REQ-016 In FETCH, on !ack, !redirect: stay in FETCH.
- ifid_valid <= 0 if !stall (bubble); IF/ID unchanged if stall.
REQ-017 In HOLD, on !stall: ifid <= hold buffer, ifid_valid <= 1, go to FETCH.
- On stall, remain in HOLD.
REQ-018 Redirect SHALL override stall. Next cycle: ifid_valid=0, hold buffer discarded.
REQ-019 Redirect in BOOT, HOLD, or FETCH-with-ack: pc <= pc_next_in, go to FETCH.
REQ-020 Redirect in FETCH without ack:
- pc_next_in saved to redir_pc
- go to DRAIN
- the outstanding request continues unchanged
REQ-021 In DRAIN: on ack, rdata discarded, pc <= redir_pc, go to FETCH.
- A further redirect in DRAIN overwrites redir_pc (latest wins).
- If ack and redirect arrive in the same DRAIN cycle, pc <= pc_next_in.
- ifid_valid stays 0 throughout DRAIN.

Reset
REQ-022 When rst=1 at a clock edge, the following SHALL apply, overriding any in-flight request without waiting for ack:
- state=BOOT, pc=16'h0000
- ifid_instr, ifid_pc, ifid_pc_plus1 = 16'h0000; ifid_valid=0
- hold buffer and redir_pc cleared
REQ-023 imem_req SHALL be 0 during reset and in the first cycle after reset release.

Configuration
REQ-024 With macro IF_BUBBLE_CNT_EN defined, SHALL add output `bubble_cnt`, 16 bits.
- Counts cycles with ifid_valid=0 while state != BOOT.
- Saturates at 16'hFFFF; reset value 0.
- Without the macro, the port and counter SHALL be absent and all other behaviour identical.

Verification
REQ-025 Reset, then ack tied 1, no stall/redirect, mux normal path:
- imem_addr 0,1,2,3 on consecutive cycles
- ifid_pc lags by one cycle
- ifid_valid=1 from the 3rd cycle after release
REQ-026 pc=16'hFFFF, fetch acked -> next_pc_normal=0; next imem_addr=16'h0000; ifid_pc_plus1=16'h0000.
REQ-027 Stall asserted in the cycle ack returns instr 16'hA5A5 at pc=5:
- 3 stall cycles: IF/ID frozen, imem_req=0
- stall drop -> ifid_instr=16'hA5A5, ifid_pc=5 next cycle
REQ-028 Ack delayed 3 cycles; redirect to 16'h0040 in the first wait cycle:
- imem_addr held until ack
- returned word not presented (ifid_valid=0)
- next imem_addr=16'h0040
REQ-029 Redirect and stall both high with hold buffer full:
- ifid_valid=0 next cycle
- buffered word never presented
- fetch resumes at pc_next_in
REQ-030 rst asserted mid-DRAIN -> BOOT, pc=0, imem_req=0; with IF_BUBBLE_CNT_EN, bubble_cnt=0.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: instruction-fetch stage with PC register, fetch request FSM,
// one-entry hold buffer for decode back-pressure, and the IF/ID pipeline register.
//
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   pc_next_in         - PC chosen by the upstream PC mux
//   redirect           - taken jump/branch; flushes fetch and IF/ID
//   stall              - decode cannot accept; IF/ID holds
//   next_pc_normal     - pc+1 (combinational), feeds the mux normal input
//   imem_req/imem_addr - instruction fetch request and address
//   imem_ack/imem_rdata- fetch completion and instruction word
//   ifid_instr/ifid_pc/ifid_pc_plus1/ifid_valid - IF/ID register
//   bubble_cnt         - saturating count of non-BOOT cycles with ifid_valid=0
//                        (present only when IF_BUBBLE_CNT_EN is defined)
//
// Configuration macro: IF_BUBBLE_CNT_EN

module pc_fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_next_in,
    input  logic        redirect,
    input  logic        stall,
    output logic [15:0] next_pc_normal,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_plus1,
    output logic        ifid_valid
`ifdef IF_BUBBLE_CNT_EN
    ,
    output logic [15:0] bubble_cnt
`endif
);

    localparam int unsigned XLEN = 16;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [XLEN-1:0]   pc, pc_d;
    logic              req_d;
    logic [XLEN-1:0]   ifid_instr_d, ifid_pc_d, ifid_pc_plus1_d;
    logic              ifid_valid_d;
    logic [XLEN-1:0]   hold_instr, hold_pc, hold_pc_plus1;
    logic [XLEN-1:0]   hold_instr_d, hold_pc_d, hold_pc_plus1_d;
    logic [XLEN-1:0]   redir_pc, redir_pc_d;

    // pc+1 wraps naturally at 16 bits
    assign next_pc_normal = pc + XLEN'(1);
    assign imem_addr      = pc;

    // Next-state and datapath decode
    always_comb begin
        state_d         = state;
        pc_d            = pc;
        ifid_instr_d    = ifid_instr;
        ifid_pc_d       = ifid_pc;
        ifid_pc_plus1_d = ifid_pc_plus1;
        ifid_valid_d    = ifid_valid;
        hold_instr_d    = hold_instr;
        hold_pc_d       = hold_pc;
        hold_pc_plus1_d = hold_pc_plus1;
        redir_pc_d      = redir_pc;

        case (state)
            S_BOOT: begin
                ifid_valid_d = 1'b0;
                state_d      = S_FETCH;
                if (redirect) begin
                    pc_d = pc_next_in;
                end
            end

            S_FETCH: begin
                if (redirect) begin
                    ifid_valid_d = 1'b0;
                    if (imem_ack) begin
                        pc_d = pc_next_in;
                    end else begin
                        // Request already issued: let it finish, then jump
                        redir_pc_d = pc_next_in;
                        state_d    = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_next_in;
                    if (stall) begin
                        hold_instr_d    = imem_rdata;
                        hold_pc_d       = pc;
                        hold_pc_plus1_d = next_pc_normal;
                        state_d         = S_HOLD;
                    end else begin
                        ifid_instr_d    = imem_rdata;
                        ifid_pc_d       = pc;
                        ifid_pc_plus1_d = next_pc_normal;
                        ifid_valid_d    = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_valid_d = 1'b0;
                end
            end

            S_DRAIN: begin
                ifid_valid_d = 1'b0;
                if (redirect) begin
                    redir_pc_d = pc_next_in;
                end
                if (imem_ack) begin
                    // Returned word belongs to the flushed path and is dropped
                    pc_d    = redirect ? pc_next_in : redir_pc;
                    state_d = S_FETCH;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    ifid_valid_d = 1'b0;
                    pc_d         = pc_next_in;
                    state_d      = S_FETCH;
                end else if (!stall) begin
                    ifid_instr_d    = hold_instr;
                    ifid_pc_d       = hold_pc;
                    ifid_pc_plus1_d = hold_pc_plus1;
                    ifid_valid_d    = 1'b1;
                    state_d         = S_FETCH;
                end
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase

        // Request is a registered decode of the next state
        req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_BOOT;
            pc            <= '0;
            imem_req      <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus1 <= '0;
            ifid_valid    <= 1'b0;
            hold_instr    <= '0;
            hold_pc       <= '0;
            hold_pc_plus1 <= '0;
            redir_pc      <= '0;
        end else begin
            state         <= state_d;
            pc            <= pc_d;
            imem_req      <= req_d;
            ifid_instr    <= ifid_instr_d;
            ifid_pc       <= ifid_pc_d;
            ifid_pc_plus1 <= ifid_pc_plus1_d;
            ifid_valid    <= ifid_valid_d;
            hold_instr    <= hold_instr_d;
            hold_pc       <= hold_pc_d;
            hold_pc_plus1 <= hold_pc_plus1_d;
            redir_pc      <= redir_pc_d;
        end
    end

`ifdef IF_BUBBLE_CNT_EN
    logic [XLEN-1:0] bubble_cnt_d;

    // Saturating bubble counter; BOOT cycles are not bubbles
    always_comb begin
        bubble_cnt_d = bubble_cnt;
        if ((state != S_BOOT) && !ifid_valid && (bubble_cnt != {XLEN{1'b1}})) begin
            bubble_cnt_d = bubble_cnt + XLEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else begin
            bubble_cnt <= bubble_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed bench for pc_fetch_stage. Expected fetch
// addresses and IF/ID entries are queued by the stimulus; a negedge monitor
// pops and compares them whenever a fetch completes (req && ack) or decode
// consumes an IF/ID entry (valid && !stall). Point checks cover reset,
// back-pressure, redirect and wrap-around cases.

module tb_pc_fetch_stage;

    logic        clk;
    logic        rst;
    logic [15:0] pc_next_in;
    logic        redirect;
    logic        stall;
    logic [15:0] next_pc_normal;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus1;
    logic        ifid_valid;
`ifdef IF_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    logic [15:0] tgt;
    int          n_checks;
    int          n_fail;

    logic [15:0] fetch_q[$];
    logic [47:0] ifid_q[$];

    pc_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pc_next_in     (pc_next_in),
        .redirect       (redirect),
        .stall          (stall),
        .next_pc_normal (next_pc_normal),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus1  (ifid_pc_plus1),
        .ifid_valid     (ifid_valid)
`ifdef IF_BUBBLE_CNT_EN
        ,
        .bubble_cnt     (bubble_cnt)
`endif
    );

    // Upstream PC mux and instruction memory contents (word = addr ^ 16'hA5A0)
    assign pc_next_in = redirect ? tgt : next_pc_normal;
    assign imem_rdata = imem_addr ^ 16'hA5A0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_fetch(input logic [15:0] a);
        fetch_q.push_back(a);
    endtask

    task automatic push_ifid(input logic [15:0] instr, input logic [15:0] pc, input logic [15:0] pc1);
        ifid_q.push_back({instr, pc, pc1});
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [15:0] ea;
        logic [47:0] ee;
        if (imem_req === 1'b1 && imem_ack === 1'b1) begin
            n_checks++;
            if (fetch_q.size() == 0) begin
                n_fail++;
                $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
            end else begin
                ea = fetch_q.pop_front();
                if (imem_addr !== ea) begin
                    n_fail++;
                    $display("FAIL fetch_addr: got %h expected %h", imem_addr, ea);
                end
            end
        end
        if (ifid_valid === 1'b1 && stall === 1'b0) begin
            n_checks++;
            if (ifid_q.size() == 0) begin
                n_fail++;
                $display("FAIL ifid_unexpected: got %h/%h/%h expected no entry",
                         ifid_instr, ifid_pc, ifid_pc_plus1);
            end else begin
                ee = ifid_q.pop_front();
                if ({ifid_instr, ifid_pc, ifid_pc_plus1} !== ee) begin
                    n_fail++;
                    $display("FAIL ifid_entry: got %h/%h/%h expected %h/%h/%h",
                             ifid_instr, ifid_pc, ifid_pc_plus1, ee[47:32], ee[31:16], ee[15:0]);
                end
            end
        end
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        imem_ack = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        tgt      = 16'h0000;

        // Reset state
        tick();
        tick();
        chk("rst_req",       16'(imem_req), 16'h0);
        chk("rst_valid",     16'(ifid_valid), 16'h0);
        chk("rst_addr",      imem_addr, 16'h0000);
        chk("rst_instr",     ifid_instr, 16'h0000);
        chk("rst_ifid_pc",   ifid_pc, 16'h0000);
        chk("rst_pc_plus1",  ifid_pc_plus1, 16'h0000);
        chk("rst_next_pc",   next_pc_normal, 16'h0001);
`ifdef IF_BUBBLE_CNT_EN
        chk("rst_bubble",    bubble_cnt, 16'h0000);
`endif

        // Zero-wait streaming from reset
        for (int i = 0; i < 4; i++) begin
            push_fetch(16'(i));
            push_ifid(16'(i) ^ 16'hA5A0, 16'(i), 16'(i + 1));
        end
        rst      = 1'b0;
        imem_ack = 1'b1;
        chk("boot_req", 16'(imem_req), 16'h0);                   // C1 BOOT
        tick();                                                  // C2
        chk("s1_req", 16'(imem_req), 16'h1);
        chk("s1_addr0", imem_addr, 16'h0000);
        chk("s1_valid_c2", 16'(ifid_valid), 16'h0);
        tick();                                                  // C3
        chk("s1_valid_c3", 16'(ifid_valid), 16'h1);
        chk("s1_lag0", ifid_pc, 16'h0000);
        chk("s1_addr1", imem_addr, 16'h0001);
        tick();                                                  // C4
        chk("s1_addr2", imem_addr, 16'h0002);
        chk("s1_lag1", ifid_pc, 16'h0001);
        tick();                                                  // C5
        chk("s1_addr3", imem_addr, 16'h0003);
        chk("s1_lag2", ifid_pc, 16'h0002);
        tick();                                                  // C6
        chk("s1_lag3", ifid_pc, 16'h0003);
        imem_ack = 1'b0;
        rst      = 1'b1;
        tick();                                                  // C7 BOOT

        // Wrap-around at 16'hFFFF via redirect in BOOT
        rst      = 1'b0;
        redirect = 1'b1;
        tgt      = 16'hFFFF;
        chk("boot2_req", 16'(imem_req), 16'h0);
        push_fetch(16'hFFFF);
        push_fetch(16'h0000);
        push_ifid(16'h5A5F, 16'hFFFF, 16'h0000);
        push_ifid(16'hA5A0, 16'h0000, 16'h0001);
        tick();                                                  // C8
        redirect = 1'b0;
        imem_ack = 1'b1;
        chk("wrap_addr", imem_addr, 16'hFFFF);
        chk("wrap_next_pc", next_pc_normal, 16'h0000);
        tick();                                                  // C9
        chk("wrap_ifid_pc", ifid_pc, 16'hFFFF);
        chk("wrap_pc_plus1", ifid_pc_plus1, 16'h0000);
        chk("wrap_addr_next", imem_addr, 16'h0000);
        tick();                                                  // C10
        imem_ack = 1'b0;
        tick();                                                  // C11
        chk("bubble_valid", 16'(ifid_valid), 16'h0);

        // Stall in the cycle 16'hA5A5 returns at pc=5
        for (int i = 1; i < 6; i++) begin
            push_fetch(16'(i));
        end
        push_ifid(16'hA5A1, 16'h0001, 16'h0002);
        push_ifid(16'hA5A2, 16'h0002, 16'h0003);
        push_ifid(16'hA5A3, 16'h0003, 16'h0004);
        push_ifid(16'hA5A4, 16'h0004, 16'h0005);
        push_ifid(16'hA5A5, 16'h0005, 16'h0006);
        imem_ack = 1'b1;
        tick();                                                  // C12
        tick();                                                  // C13
        tick();                                                  // C14
        tick();                                                  // C15
        stall = 1'b1;
        chk("stall_addr5", imem_addr, 16'h0005);
        for (int i = 0; i < 2; i++) begin
            tick();                                              // C16, C17
            chk("hold_req", 16'(imem_req), 16'h0);
            chk("hold_ifid_pc", ifid_pc, 16'h0004);
            chk("hold_instr", ifid_instr, 16'hA5A4);
        end
        tick();                                                  // C18
        stall = 1'b0;
        tick();                                                  // C19
        chk("release_instr", ifid_instr, 16'hA5A5);
        chk("release_pc", ifid_pc, 16'h0005);
        chk("release_addr", imem_addr, 16'h0006);
        imem_ack = 1'b0;
        tick();                                                  // C20

        // Redirect while the fetch at 6 waits 3 cycles for ack
        redirect = 1'b1;
        tgt      = 16'h0040;
        push_fetch(16'h0006);
        push_fetch(16'h0040);
        tick();                                                  // C21
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drain_addr", imem_addr, 16'h0006);
            chk("drain_req", 16'(imem_req), 16'h1);
            chk("drain_valid", 16'(ifid_valid), 16'h0);
            tick();                                              // C22, C23
        end
        imem_ack = 1'b1;
        chk("drain_addr_ack", imem_addr, 16'h0006);
        tick();                                                  // C24
        chk("redir_addr", imem_addr, 16'h0040);
        chk("redir_valid", 16'(ifid_valid), 16'h0);

        // Redirect + stall with the hold buffer full
        stall = 1'b1;
        push_fetch(16'h0080);
        push_ifid(16'hA520, 16'h0080, 16'h0081);
        tick();                                                  // C25 HOLD
        chk("hold2_req", 16'(imem_req), 16'h0);
        redirect = 1'b1;
        tgt      = 16'h0080;
        tick();                                                  // C26
        redirect = 1'b0;
        stall    = 1'b0;
        chk("flush_valid", 16'(ifid_valid), 16'h0);
        chk("flush_addr", imem_addr, 16'h0080);
        chk("flush_req", 16'(imem_req), 16'h1);
        tick();                                                  // C27
        imem_ack = 1'b0;
        tick();                                                  // C28

        // Reset in the middle of DRAIN
        redirect = 1'b1;
        tgt      = 16'h0100;
        tick();                                                  // C29 DRAIN
        redirect = 1'b0;
        chk("pre_rst_req", 16'(imem_req), 16'h1);
        chk("pre_rst_addr", imem_addr, 16'h0081);
        rst = 1'b1;
        tick();                                                  // C30 BOOT
        chk("drst_req", 16'(imem_req), 16'h0);
        chk("drst_addr", imem_addr, 16'h0000);
        chk("drst_valid", 16'(ifid_valid), 16'h0);
        chk("drst_ifid_pc", ifid_pc, 16'h0000);
`ifdef IF_BUBBLE_CNT_EN
        chk("drst_bubble", bubble_cnt, 16'h0000);
`endif
        rst      = 1'b0;
        imem_ack = 1'b1;
        push_fetch(16'h0000);
        push_ifid(16'hA5A0, 16'h0000, 16'h0001);
        tick();                                                  // C31
        chk("restart_addr", imem_addr, 16'h0000);
        tick();                                                  // C32
        imem_ack = 1'b0;
`ifdef IF_BUBBLE_CNT_EN
        chk("bubble_1", bubble_cnt, 16'h0001);
`endif
        tick();                                                  // C33
        tick();                                                  // C34
`ifdef IF_BUBBLE_CNT_EN
        chk("bubble_2", bubble_cnt, 16'h0002);
`endif
        tick();
        tick();

        chk("fetch_q_empty", 16'(fetch_q.size()), 16'h0);
        chk("ifid_q_empty", 16'(ifid_q.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
